// File: rtl/rank_pifo_sorter_if.sv
// rtl/rank_pifo_sorter_if.sv - upstream rank pipe and scheduler dequeue signals of the PIFO sorter
interface rank_pifo_sorter_if #(
  parameter int RANK_WIDTH = 16,
  parameter int META_WIDTH = 16,
  parameter int L2_DEPTH   = 3
);
  logic                  rank_valid;
  logic [RANK_WIDTH-1:0] rank_in;
  logic [META_WIDTH-1:0] meta_in;
  logic                  rank_remove;
  logic                  deq_req;
  logic                  deq_valid;
  logic [RANK_WIDTH-1:0] deq_rank;
  logic [META_WIDTH-1:0] deq_meta;
  logic [L2_DEPTH:0]     count;
  logic                  full;
  logic                  underflow;

  modport master (
    output rank_valid, rank_in, meta_in, deq_req,
    input  rank_remove, deq_valid, deq_rank, deq_meta, count, full, underflow
  );

  modport slave (
    input  rank_valid, rank_in, meta_in, deq_req,
    output rank_remove, deq_valid, deq_rank, deq_meta, count, full, underflow
  );
endinterface

// File: rtl/rank_pifo_sorter.sv
// rtl/rank_pifo_sorter.sv - sorted register array pulling ranks from a fall-through source, smallest-first dequeue
module rank_pifo_sorter #(
  parameter int RANK_WIDTH = 16,
  parameter int META_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int L2_DEPTH   = 3
) (
  input  logic clk,
  input  logic rst,
  rank_pifo_sorter_if.slave sif
);
  localparam int CW = L2_DEPTH + 1;

  logic [RANK_WIDTH-1:0] rank_q   [DEPTH];
  logic [META_WIDTH-1:0] meta_q   [DEPTH];
  logic [RANK_WIDTH-1:0] sh_rank  [DEPTH];
  logic [META_WIDTH-1:0] sh_meta  [DEPTH];
  logic [RANK_WIDTH-1:0] nxt_rank [DEPTH];
  logic [META_WIDTH-1:0] nxt_meta [DEPTH];
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         cnt_after;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         p;
  logic                  underflow_q;
  logic                  full;
  logic                  acc;
  logic                  fire;

  assign full = (count_q == CW'(DEPTH));
  assign acc  = sif.rank_valid & ~full & ~rst;
  assign fire = sif.deq_req & (count_q != '0);

  always_comb begin
    // Head removal happens first so the new entry is placed among the survivors.
    for (int i = 0; i < DEPTH - 1; i++) begin
      sh_rank[i] = fire ? rank_q[i+1] : rank_q[i];
      sh_meta[i] = fire ? meta_q[i+1] : meta_q[i];
    end
    sh_rank[DEPTH-1] = fire ? '0 : rank_q[DEPTH-1];
    sh_meta[DEPTH-1] = fire ? '0 : meta_q[DEPTH-1];
    cnt_after = count_q - CW'(fire);

    // Counting <= places the newcomer behind equal ranks, giving FIFO tie order.
    p = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt_after) && (sh_rank[i] <= sif.rank_in)) begin
        p = p + CW'(1);
      end
    end

    nxt_rank = sh_rank;
    nxt_meta = sh_meta;
    if (acc) begin
      if (p == '0) begin
        nxt_rank[0] = sif.rank_in;
        nxt_meta[0] = sif.meta_in;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (CW'(i) == p) begin
          nxt_rank[i] = sif.rank_in;
          nxt_meta[i] = sif.meta_in;
        end else if (CW'(i) > p) begin
          nxt_rank[i] = sh_rank[i-1];
          nxt_meta[i] = sh_meta[i-1];
        end
      end
    end
    count_nxt = cnt_after + CW'(acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rank_q[i] <= '0;
        meta_q[i] <= '0;
      end
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      rank_q  <= nxt_rank;
      meta_q  <= nxt_meta;
      count_q <= count_nxt;
      if (sif.deq_req && (count_q == '0)) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign sif.rank_remove = acc;
  assign sif.deq_valid   = (count_q != '0);
  assign sif.deq_rank    = rank_q[0];
  assign sif.deq_meta    = meta_q[0];
  assign sif.count       = count_q;
  assign sif.full        = full;
  assign sif.underflow   = underflow_q;
endmodule

// File: tb/tb_rank_pifo_sorter.sv
// tb/tb_rank_pifo_sorter.sv - directed scoreboard bench for rank_pifo_sorter
module tb_rank_pifo_sorter;
  localparam int RW = 16;
  localparam int MW = 16;
  localparam int D  = 8;
  localparam int L2 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rank_pifo_sorter_if #(.RANK_WIDTH(RW), .META_WIDTH(MW), .L2_DEPTH(L2)) bus ();

  rank_pifo_sorter #(.RANK_WIDTH(RW), .META_WIDTH(MW), .DEPTH(D), .L2_DEPTH(L2)) dut (
    .clk (clk),
    .rst (rst),
    .sif (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every fired dequeue must match the oldest expected {rank, meta}.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.deq_req && bus.deq_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL deq_unexpected: got %h expected no dequeue", {bus.deq_rank, bus.deq_meta});
        end else begin
          e = exp_q.pop_front();
          chk("deq_entry", {bus.deq_rank, bus.deq_meta}, e);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [15:0] r, input logic [15:0] m,
                     input logic d, input logic exp_rm, input string tag);
    bus.rank_valid = v;
    bus.rank_in    = r;
    bus.meta_in    = m;
    bus.deq_req    = d;
    #1 chk({tag, "_remove"}, 32'(bus.rank_remove), 32'(exp_rm));
    @(negedge clk);
    bus.rank_valid = 1'b0;
    bus.deq_req    = 1'b0;
  endtask

  task automatic push(input logic [15:0] r, input logic [15:0] m);
    cyc(1'b1, r, m, 1'b0, 1'b1, "push");
  endtask

  task automatic deq();
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "deq");
  endtask

  initial begin
    rst = 1'b1;
    bus.rank_valid = 1'b1;
    bus.rank_in    = 16'h0042;
    bus.meta_in    = 16'h0001;
    bus.deq_req    = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_deq_valid", 32'(bus.deq_valid), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_underflow", 32'(bus.underflow), 0);
    chk("rst_deq_rank", 32'(bus.deq_rank), 0);
    chk("rst_deq_meta", 32'(bus.deq_meta), 0);
    chk("rst_remove", 32'(bus.rank_remove), 0);
    rst = 1'b0;
    bus.rank_valid = 1'b0;

    // Underflow on empty array
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "uflow");
    chk("uflow_count", 32'(bus.count), 0);
    chk("uflow_flag", 32'(bus.underflow), 1);
    chk("uflow_valid", 32'(bus.deq_valid), 0);

    // Sort with FIFO ties
    push(16'd5, 16'h000A);
    push(16'd2, 16'h000B);
    push(16'd9, 16'h000C);
    push(16'd2, 16'h000D);
    chk("sort_count", 32'(bus.count), 4);
    chk("sort_head", 32'(bus.deq_rank), 2);
    chk("sort_head_meta", 32'(bus.deq_meta), 32'h000B);
    exp_q.push_back(32'h0002_000B);
    exp_q.push_back(32'h0002_000D);
    exp_q.push_back(32'h0005_000A);
    exp_q.push_back(32'h0009_000C);
    for (int k = 0; k < 4; k++) begin
      deq();
      chk("sort_drain_count", 32'(bus.count), 32'(3 - k));
    end
    chk("uflow_sticky", 32'(bus.underflow), 1);

    // Full: no accept while full, even with a same-cycle dequeue
    for (int k = 0; k < 8; k++) push(16'(17 - k), 16'(16'h0100 + 17 - k));
    chk("full_count", 32'(bus.count), 8);
    chk("full_flag", 32'(bus.full), 1);
    chk("full_head", 32'(bus.deq_rank), 10);
    cyc(1'b1, 16'd20, 16'h0020, 1'b0, 1'b0, "full_hold");
    chk("full_hold_count", 32'(bus.count), 8);
    exp_q.push_back(32'h000A_010A);
    cyc(1'b1, 16'd20, 16'h0020, 1'b1, 1'b0, "full_deq");
    chk("full_deq_count", 32'(bus.count), 7);
    chk("full_deq_flag", 32'(bus.full), 0);
    cyc(1'b1, 16'd20, 16'h0020, 1'b0, 1'b1, "refill");
    chk("refill_count", 32'(bus.count), 8);
    chk("refill_full", 32'(bus.full), 1);
    for (int k = 11; k <= 17; k++) exp_q.push_back({16'(k), 16'(16'h0100 + k)});
    exp_q.push_back(32'h0014_0020);
    for (int k = 0; k < 8; k++) deq();
    chk("full_drained", 32'(bus.count), 0);

    // Simultaneous insert and dequeue
    push(16'd3, 16'h0033);
    push(16'd7, 16'h0077);
    exp_q.push_back(32'h0003_0033);
    cyc(1'b1, 16'd1, 16'h0011, 1'b1, 1'b1, "sim1");
    chk("sim1_count", 32'(bus.count), 2);
    chk("sim1_head", 32'(bus.deq_rank), 1);
    chk("sim1_meta", 32'(bus.deq_meta), 32'h0011);
    exp_q.push_back(32'h0001_0011);
    cyc(1'b1, 16'd9, 16'h0099, 1'b1, 1'b1, "sim2");
    chk("sim2_count", 32'(bus.count), 2);
    chk("sim2_head", 32'(bus.deq_rank), 7);
    exp_q.push_back(32'h0007_0077);
    exp_q.push_back(32'h0009_0099);
    deq();
    deq();

    // Boundary ranks and ties at the maximum rank
    push(16'hFFFF, 16'h0001);
    push(16'h0000, 16'h0002);
    push(16'hFFFF, 16'h0003);
    chk("bound_head", 32'(bus.deq_rank), 0);
    exp_q.push_back(32'h0000_0002);
    exp_q.push_back(32'hFFFF_0001);
    exp_q.push_back(32'hFFFF_0003);
    for (int k = 0; k < 3; k++) deq();
    chk("bound_drained", 32'(bus.count), 0);

    // Asynchronous reset mid-operation with an upstream head pending
    push(16'd4, 16'h0044);
    push(16'd5, 16'h0055);
    push(16'd6, 16'h0066);
    chk("mid_count", 32'(bus.count), 3);
    bus.rank_valid = 1'b1;
    bus.rank_in    = 16'd7;
    bus.meta_in    = 16'h0077;
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_valid", 32'(bus.deq_valid), 0);
    chk("mid_rst_remove", 32'(bus.rank_remove), 0);
    chk("mid_rst_uflow", 32'(bus.underflow), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_remove", 32'(bus.rank_remove), 1);
    @(negedge clk);
    bus.rank_valid = 1'b0;
    chk("post_rst_count", 32'(bus.count), 1);
    chk("post_rst_head", 32'(bus.deq_rank), 7);
    chk("post_rst_meta", 32'(bus.deq_meta), 32'h0077);
    exp_q.push_back(32'h0007_0077);
    deq();
    chk("final_count", 32'(bus.count), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
